// File: rtl/spmp_csr_file.sv
// rtl/spmp_csr_file.sv - SPMP cfg/addr/switch CSR state with WARL writes and an entry-clear sequencer.
// Optional feature macro: SPMP_CHANGE_FLUSH_EN (flush pulse on any effective configuration change).
module spmp_csr_file #(
  parameter int unsigned NrSPMPEntries = 8,
  parameter int unsigned PLEN          = 56
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     req_valid_i,
  output logic                                     req_ready_o,
  input  logic                                     req_we_i,
  input  logic [7:0]                               req_addr_i,
  input  logic [63:0]                              req_wdata_i,
  output logic                                     rsp_valid_o,
  output logic [63:0]                              rsp_rdata_o,
  output logic                                     rsp_err_o,
  input  logic                                     clear_i,
  output logic                                     busy_o,
  output logic                                     clear_done_o,
  output logic                                     flush_o,
  output logic [NrSPMPEntries-1:0][7:0]            spmpcfg_o,
  output logic [NrSPMPEntries-1:0][PLEN-3:0]       spmpaddr_o,
  output logic [63:0]                              spmpswitch_o
);

  localparam int unsigned N  = NrSPMPEntries;
  localparam int unsigned AW = PLEN - 2;
  localparam logic [5:0]  LAST_CNT = 6'(N - 1);
  localparam logic [63:0] SW_MASK  = (N >= 64) ? {64{1'b1}} : ((64'd1 << N) - 64'd1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [N-1:0][7:0]     cfg_q, cfg_d;
  logic [N-1:0][AW-1:0]  addr_q, addr_d;
  logic [63:0]           sw_q, sw_d;

  logic                  rsp_valid_q, rsp_err_q;
  logic [63:0]           rsp_rdata_q;

  logic [1:0]            region;
  logic [5:0]            idx;
  logic                  legal;
  logic                  accept;
  logic [63:0]           rd_val;
  logic [7:0]            wbyte;

  assign region = req_addr_i[7:6];
  assign idx    = req_addr_i[5:0];

  assign req_ready_o = rst_ni && (state_q == IDLE) && !clear_i;
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    legal = 1'b0;
    case (region)
      2'b00:   legal = ((32'(idx) << 3) < N);
      2'b01:   legal = (32'(idx) < N);
      2'b10:   legal = (idx == 6'd0);
      default: legal = 1'b0;
    endcase
  end

  // Old value of the addressed register; entries beyond N stay zero in the cfg word.
  always_comb begin
    rd_val = 64'd0;
    case (region)
      2'b00: begin
        for (int e = 0; e < int'(N); e++) begin
          if ((e / 8) == int'(idx)) rd_val[(e % 8) * 8 +: 8] = cfg_q[e];
        end
      end
      2'b01: begin
        for (int e = 0; e < int'(N); e++) begin
          if (e == int'(idx)) rd_val = 64'(addr_q[e]);
        end
      end
      2'b10:   rd_val = sw_q;
      default: rd_val = 64'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    addr_d  = addr_q;
    sw_d    = sw_q;
    wbyte   = 8'd0;
    case (state_q)
      IDLE: begin
        if (clear_i) begin
          state_d = CLEAR;
          cnt_d   = 6'd0;
        end else if (accept && req_we_i && legal) begin
          case (region)
            2'b00: begin
              for (int e = 0; e < int'(N); e++) begin
                if ((e / 8) == int'(idx)) begin
                  wbyte = req_wdata_i[(e % 8) * 8 +: 8];
                  // S-mode with xwr=000 is reserved: that entry keeps its old byte.
                  if (!(wbyte[7] && (wbyte[2:0] == 3'b000)))
                    cfg_d[e] = {wbyte[7], 2'b00, wbyte[4:0]};
                end
              end
            end
            2'b01: begin
              for (int e = 0; e < int'(N); e++) begin
                if (e == int'(idx)) addr_d[e] = req_wdata_i[AW-1:0];
              end
            end
            2'b10:   sw_d = req_wdata_i & SW_MASK;
            default: ;
          endcase
        end
      end
      CLEAR: begin
        for (int e = 0; e < int'(N); e++) begin
          if (e == int'(cnt_q)) begin
            cfg_d[e]  = 8'd0;
            addr_d[e] = '0;
          end
        end
        if (cnt_q == 6'd0) sw_d = 64'd0;
        if (cnt_q == LAST_CNT) state_d = IDLE;
        else cnt_d = cnt_q + 6'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= 6'd0;
      cfg_q       <= '0;
      addr_q      <= '0;
      sw_q        <= 64'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 64'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cfg_q       <= cfg_d;
      addr_q      <= addr_d;
      sw_q        <= sw_d;
      rsp_valid_q <= accept;
      rsp_err_q   <= accept && !legal;
      rsp_rdata_q <= (accept && legal) ? rd_val : 64'd0;
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_err_o    = rsp_err_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign busy_o       = (state_q == CLEAR);
  assign clear_done_o = (state_q == CLEAR) && (cnt_q == LAST_CNT);
  assign spmpcfg_o    = cfg_q;
  assign spmpaddr_o   = addr_q;
  assign spmpswitch_o = sw_q;

`ifdef SPMP_CHANGE_FLUSH_EN
  logic changed;
  logic flush_q;

  assign changed = (cfg_d != cfg_q) || (addr_d != addr_q) || (sw_d != sw_q);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) flush_q <= 1'b0;
    else         flush_q <= accept && req_we_i && legal && changed;
  end

  assign flush_o = flush_q || clear_done_o;
`else
  assign flush_o = 1'b0;
`endif

endmodule

// File: tb/tb_spmp_csr_file.sv
// tb/tb_spmp_csr_file.sv - directed self-checking bench for spmp_csr_file (N=8, PLEN=56).
module tb_spmp_csr_file;
  localparam int N    = 8;
  localparam int PLEN = 56;

  logic                       clk;
  logic                       rst_ni;
  logic                       req_valid;
  logic                       req_ready;
  logic                       req_we;
  logic [7:0]                 req_addr;
  logic [63:0]                req_wdata;
  logic                       rsp_valid;
  logic [63:0]                rsp_rdata;
  logic                       rsp_err;
  logic                       clear;
  logic                       busy;
  logic                       clear_done;
  logic                       flush;
  logic [N-1:0][7:0]          spmpcfg;
  logic [N-1:0][PLEN-3:0]     spmpaddr;
  logic [63:0]                spmpswitch;

  spmp_csr_file #(.NrSPMPEntries(N), .PLEN(PLEN)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .clear_i(clear), .busy_o(busy), .clear_done_o(clear_done), .flush_o(flush),
    .spmpcfg_o(spmpcfg), .spmpaddr_o(spmpaddr), .spmpswitch_o(spmpswitch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic last_flush;
  logic [N-1:0][7:0]      exp_cfg;
  logic [N-1:0][PLEN-3:0] exp_addr;
  logic [63:0]            exp_sw;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_cfg"}, spmpcfg, exp_cfg);
    for (int i = 0; i < N; i++) check($sformatf("%s_addr%0d", tag, i), 64'(spmpaddr[i]), 64'(exp_addr[i]));
    check({tag, "_sw"}, spmpswitch, exp_sw);
  endtask

  task automatic xfer(input string tag, input logic we, input logic [7:0] a, input logic [63:0] wd,
                      input logic [63:0] exp_rd, input logic exp_err);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    #1 check({tag, "_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0; req_we = 1'b0;
    check({tag, "_rv"}, 64'(rsp_valid), 64'd1);
    check({tag, "_rd"}, rsp_rdata, exp_rd);
    check({tag, "_err"}, 64'(rsp_err), 64'(exp_err));
    last_flush = flush;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles;
    int done_at;
    logic flush_at_done;

    rst_ni = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'd0; req_wdata = 64'd0; clear = 1'b0;
    exp_cfg = '0; exp_addr = '0; exp_sw = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_rv", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(clear_done), 64'd0);
    check("rst_flush", 64'(flush), 64'd0);
    check_state("rst");
    @(negedge clk) rst_ni = 1'b1;

    xfer("rd_addr0", 1'b0, 8'h40, 64'd0, 64'd0, 1'b0);

    // Byte3 0x6B drops bits [6:5]; byte2 0x80 is reserved and keeps 0.
    xfer("wr_cfg0", 1'b1, 8'h00, 64'h0000_0000_6B80_0D0F, 64'd0, 1'b0);
    exp_cfg = 64'h0000_0000_0B00_0D0F;
    check_state("wr_cfg0");
    xfer("rd_cfg0", 1'b0, 8'h00, 64'd0, 64'h0B00_0D0F, 1'b0);
    xfer("wr_cfg0_rsv", 1'b1, 8'h00, 64'h0000_0000_0000_8000, 64'h0B00_0D0F, 1'b0);
    exp_cfg = 64'h0000_0000_0000_0D00;
    check_state("wr_cfg0_rsv");

    xfer("wr_addr1", 1'b1, 8'h41, {64{1'b1}}, 64'd0, 1'b0);
    exp_addr[1] = {(PLEN-2){1'b1}};
    check_state("wr_addr1");
    xfer("rd_addr1", 1'b0, 8'h41, 64'd0, 64'h003F_FFFF_FFFF_FFFF, 1'b0);

    xfer("wr_sw", 1'b1, 8'h80, {64{1'b1}}, 64'd0, 1'b0);
    exp_sw = 64'hFF;
    check_state("wr_sw");
    xfer("rd_sw", 1'b0, 8'h80, 64'd0, 64'hFF, 1'b0);

    xfer("wr_addr8", 1'b1, 8'h48, 64'h1234, 64'd0, 1'b1);
    xfer("wr_cfg1", 1'b1, 8'h01, {64{1'b1}}, 64'd0, 1'b1);
    xfer("wr_ill", 1'b1, 8'hC0, {64{1'b1}}, 64'd0, 1'b1);
    xfer("wr_sw1", 1'b1, 8'h81, 64'd0, 64'd0, 1'b1);
    xfer("rd_addr9", 1'b0, 8'h49, 64'd0, 64'd0, 1'b1);
    check_state("after_err");

    xfer("prg_a0", 1'b1, 8'h40, 64'd1, 64'd0, 1'b0);
    xfer("prg_a1", 1'b1, 8'h41, 64'd2, 64'h003F_FFFF_FFFF_FFFF, 1'b0);
    xfer("prg_a2", 1'b1, 8'h42, 64'd3, 64'd0, 1'b0);
    xfer("prg_a3", 1'b1, 8'h43, 64'd4, 64'd0, 1'b0);

    // Clear wins over a simultaneous write request.
    @(negedge clk);
    clear = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h45; req_wdata = 64'd7;
    #1 check("clr_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1 clear = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    check("clr_no_rsp", 64'(rsp_valid), 64'd0);
    busy_cycles = 0; done_at = -1; flush_at_done = 1'b0;
    for (int c = 0; c < 20 && busy; c++) begin
      if (clear_done) begin
        done_at = busy_cycles;
        flush_at_done = flush;
      end
      busy_cycles++;
      @(posedge clk);
      #1;
    end
    check("clr_busy_cycles", 64'(busy_cycles), 64'd8);
    check("clr_done_at", 64'(done_at), 64'd7);
`ifdef SPMP_CHANGE_FLUSH_EN
    check("clr_flush", 64'(flush_at_done), 64'd1);
`else
    check("clr_flush", 64'(flush_at_done), 64'd0);
`endif
    check("clr_done_low", 64'(clear_done), 64'd0);
    exp_cfg = '0; exp_addr = '0; exp_sw = 64'd0;
    check_state("after_clear");

    xfer("prg_a6", 1'b1, 8'h46, 64'h123, 64'd0, 1'b0);
    xfer("prg_sw", 1'b1, 8'h80, 64'h5, 64'd0, 1'b0);
    @(negedge clk) clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b0;
    check("mid_busy_pre", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_done", 64'(clear_done), 64'd0);
    check_state("mid_rst");
    @(negedge clk) rst_ni = 1'b1;

`ifdef SPMP_CHANGE_FLUSH_EN
    xfer("fl_chg", 1'b1, 8'h40, 64'h10, 64'd0, 1'b0);
    check("fl_chg_pulse", 64'(last_flush), 64'd1);
    @(posedge clk);
    #1 check("fl_chg_once", 64'(flush), 64'd0);
    xfer("fl_same", 1'b1, 8'h40, 64'h10, 64'h10, 1'b0);
    check("fl_same_none", 64'(last_flush), 64'd0);
`else
    xfer("fl_chg", 1'b1, 8'h40, 64'h10, 64'd0, 1'b0);
    check("fl_tied", 64'(last_flush), 64'd0);
`endif
    exp_addr[0] = 54'h10;
    check_state("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
